// File: rtl/match_select_pkg.sv
// Shared types and sizing for the Deflate match-select stage: lane geometry,
// token kinds, scheduler states and the max-tree candidate record.
package match_select_pkg;

  localparam int LANES   = 16;
  localparam int LEN_W   = 5;
  localparam int IDX_W   = 4;
  localparam int MIN_LEN = 3;

  typedef enum logic [1:0] {
    KIND_LIT   = 2'd0,
    KIND_MATCH = 2'd1,
    KIND_END   = 2'd2
  } kind_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [IDX_W-1:0] idx;
  } cand_t;

  // Strict '>' keeps the lower-index operand on a tie.
  function automatic cand_t pick(cand_t lo, cand_t hi);
    return (hi.len > lo.len) ? hi : lo;
  endfunction

endpackage

// File: rtl/match_select_max16.sv
// Combinational 16-lane masked max/argmax; four pairwise compare levels, the
// lower lane always sits on the 'lo' side so ties resolve to the lowest index.
module match_select_max16
  import match_select_pkg::*;
(
  input  logic [LANES*LEN_W-1:0] len,
  input  logic [LANES-1:0]       mask,
  output logic [LEN_W-1:0]       max_len,
  output logic [IDX_W-1:0]       max_idx
);

  cand_t l0 [16];
  cand_t l1 [8];
  cand_t l2 [4];
  cand_t l3 [2];
  cand_t l4;

  for (genvar i = 0; i < 16; i++) begin : g_l0
    assign l0[i].len = mask[i] ? len[i*LEN_W +: LEN_W] : '0;
    assign l0[i].idx = IDX_W'(i);
  end
  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = pick(l0[2*i], l0[2*i+1]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = pick(l1[2*i], l1[2*i+1]);
  end
  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = pick(l2[2*i], l2[2*i+1]);
  end
  assign l4 = pick(l3[0], l3[1]);

  assign max_len = l4.len;
  assign max_idx = l4.idx;

endmodule

// File: rtl/match_select_ctrl.sv
// Deflate per-position match scheduler: literal/match/end-only token decision,
// skip of covered windows, one registered output stage with valid/ready.
// Optional stats counters: define MATCH_SELECT_STATS_EN.
module match_select_ctrl
  import match_select_pkg::*;
(
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*LEN_W-1:0] in_len,
  input  logic [LANES-1:0]       in_mask,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_kind,
  output logic [LEN_W-1:0]       out_len,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last
`ifdef MATCH_SELECT_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [31:0]            stat_lit_cnt,
  output logic [31:0]            stat_match_cnt
`endif
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] skip_q, skip_d;
  logic [LEN_W-1:0] max_len;
  logic [IDX_W-1:0] max_idx;
  logic             accept;

  logic             tok_load;
  kind_t            tok_kind, kind_q;
  logic [LEN_W-1:0] tok_len;
  logic [IDX_W-1:0] tok_idx;
  logic             tok_last;

  match_select_max16 u_max (
    .len     (in_len),
    .mask    (in_mask),
    .max_len (max_len),
    .max_idx (max_idx)
  );

  // Reset gating keeps upstream from handing over a window during reset.
  assign in_ready = ap_rst_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can infer a latch.
    state_d  = state_q;
    skip_d   = skip_q;
    tok_load = 1'b0;
    tok_kind = KIND_LIT;
    tok_len  = '0;
    tok_idx  = '0;
    tok_last = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_RUN: begin
          tok_load = 1'b1;
          tok_last = in_last;
          if (max_len >= LEN_W'(MIN_LEN)) begin
            tok_kind = KIND_MATCH;
            tok_len  = max_len;
            tok_idx  = max_idx;
          end
          // A match on the block's last window has nothing left to cover.
          if (in_last) begin
            skip_d = '0;
          end else if (max_len >= LEN_W'(MIN_LEN)) begin
            skip_d  = max_len - LEN_W'(1);
            state_d = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (in_last) begin
            tok_load = 1'b1;
            tok_kind = KIND_END;
            tok_last = 1'b1;
            skip_d   = '0;
            state_d  = ST_RUN;
          end else begin
            skip_d = skip_q - LEN_W'(1);
            if (skip_q == LEN_W'(1)) state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_RUN;
      skip_q    <= '0;
      out_valid <= 1'b0;
      kind_q    <= KIND_LIT;
      out_len   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (tok_load) begin
        out_valid <= 1'b1;
        kind_q    <= tok_kind;
        out_len   <= tok_len;
        out_idx   <= tok_idx;
        out_last  <= tok_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_kind = kind_q;

`ifdef MATCH_SELECT_STATS_EN
  logic tok_taken;
  assign tok_taken = out_valid & out_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_lit_cnt   <= '0;
      stat_match_cnt <= '0;
    end else if (stat_clr) begin
      stat_lit_cnt   <= '0;
      stat_match_cnt <= '0;
    end else if (tok_taken) begin
      if (kind_q == KIND_LIT && stat_lit_cnt != '1)
        stat_lit_cnt <= stat_lit_cnt + 32'd1;
      if (kind_q == KIND_MATCH && stat_match_cnt != '1)
        stat_match_cnt <= stat_match_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_match_select_ctrl.sv
// Self-checking bench for match_select_ctrl: directed scenarios plus random
// traffic, all compared against a window-level behavioural model.
module tb_match_select_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_len;
  logic [15:0] in_mask;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [4:0]  out_len;
  logic [3:0]  out_idx;
  logic        out_last;
`ifdef MATCH_SELECT_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_lit_cnt;
  logic [31:0] stat_match_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending output token and number of windows still covered.
  bit m_valid;
  int m_kind, m_len, m_idx, m_last;
  int m_rem;
  int m_emitted;
  int seen_taken;

  always #5 clk = ~clk;

  match_select_ctrl dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_len    (in_len),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_len   (out_len),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef MATCH_SELECT_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_lit_cnt   (stat_lit_cnt),
    .stat_match_cnt (stat_match_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [79:0] lane(input int i, input int v);
    logic [79:0] r;
    r = '0;
    r[i*5 +: 5] = 5'(v);
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_kind = 0; m_len = 0; m_idx = 0; m_last = 0;
    m_rem = 0;
  endtask

  task automatic emit(input int k, input int l, input int ix, input int lst);
    m_valid = 1'b1;
    m_kind = k; m_len = l; m_idx = ix; m_last = lst;
    m_emitted++;
  endtask

  // Called just after a negedge: drive one cycle of inputs, compare outputs,
  // advance the model across the following posedge.
  task automatic step(input bit v, input logic [79:0] lv, input logic [15:0] mk,
                      input bit lst, input bit rdy);
    bit exp_rdy, acc;
    int mx, ai, val;
    in_valid  = v;
    in_len    = lv;
    in_mask   = mk;
    in_last   = lst;
    out_ready = rdy;
    #1;
    exp_rdy = !m_valid || rdy;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_kind", 32'(out_kind), m_kind);
      check("out_len",  32'(out_len),  m_len);
      check("out_idx",  32'(out_idx),  m_idx);
      check("out_last", 32'(out_last), m_last);
    end
    if (out_valid && rdy) seen_taken++;
    acc = v && exp_rdy;
    if (m_valid && rdy) m_valid = 1'b0;
    if (acc) begin
      if (m_rem > 0) begin
        if (lst) begin
          emit(2, 0, 0, 1);
          m_rem = 0;
        end else begin
          m_rem--;
        end
      end else begin
        mx = 0; ai = 0;
        for (int i = 0; i < 16; i++) begin
          val = mk[i] ? int'(lv[i*5 +: 5]) : 0;
          if (val > mx) begin mx = val; ai = i; end
        end
        if (mx >= 3) begin
          emit(1, mx, ai, int'(lst));
          m_rem = lst ? 0 : mx - 1;
        end else begin
          emit(0, 0, 0, int'(lst));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_tok(input string tag, input int k, input int l, input int ix, input int lst);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_kind"},  32'(out_kind),  k);
    check({tag, "_len"},   32'(out_len),   l);
    check({tag, "_idx"},   32'(out_idx),   ix);
    check({tag, "_last"},  32'(out_last),  lst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 16'hFFFF, 1'b0, 1'b1);
  endtask

  initial begin
    logic [79:0] lv;
    logic [4:0]  snap_len;
    logic [1:0]  snap_kind;
    logic [3:0]  snap_idx;
    int          r;

    m_emitted = 0;
    seen_taken = 0;
    model_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_len = '1; in_mask = '1; in_last = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_kind",  32'(out_kind),  32'd0);
    check("rst_out_len",   32'(out_len),   32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lane 5 = 7: match, six suppressed windows, then a literal.
    step(1'b1, lane(5, 7), 16'hFFFF, 1'b0, 1'b1);
    check_tok("s1_match", 1, 7, 5, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, '0, 16'hFFFF, 1'b0, 1'b1);
      check("s1_skip_valid", 32'(out_valid), 32'd0);
    end
    step(1'b1, '0, 16'hFFFF, 1'b0, 1'b1);
    check_tok("s1_lit", 0, 0, 0, 0);

    // Tie between lanes 3 and 12 goes to lane 3.
    step(1'b1, lane(3, 9) | lane(12, 9), 16'hFFFF, 1'b0, 1'b1);
    check_tok("s2_tie", 1, 9, 3, 0);
    idle(8);

    // Maximum of 2 stays a literal; the next window proves the FSM is in RUN.
    lv = '0;
    for (int i = 0; i < 16; i++) lv[i*5 +: 5] = 5'($urandom_range(0, 2));
    lv[9*5 +: 5] = 5'd2;
    step(1'b1, lv, 16'hFFFF, 1'b0, 1'b1);
    check_tok("s3_lit", 0, 0, 0, 0);
    step(1'b1, lane(0, 3), 16'hFFFF, 1'b0, 1'b1);
    check_tok("s3_run", 1, 3, 0, 0);
    idle(2);

    // Masked lane 0 counts as zero.
    step(1'b1, lane(0, 31) | lane(1, 4), 16'hFFFE, 1'b0, 1'b1);
    check_tok("s4_mask", 1, 4, 1, 0);
    idle(3);

    // Back-pressure: token held stable, nothing accepted for 5 cycles.
    step(1'b1, lane(6, 4), 16'hFFFF, 1'b0, 1'b1);
    snap_kind = out_kind; snap_len = out_len; snap_idx = out_idx;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, lane(2, 20), 16'hFFFF, 1'b0, 1'b0);
      check("bp_kind_hold", 32'(out_kind), 32'(snap_kind));
      check("bp_len_hold",  32'(out_len),  32'(snap_len));
      check("bp_idx_hold",  32'(out_idx),  32'(snap_idx));
    end
    idle(5);

    // in_last during SKIP gives an end-only token and restarts in RUN.
    step(1'b1, lane(7, 10), 16'hFFFF, 1'b0, 1'b1);
    check_tok("s6_match", 1, 10, 7, 0);
    step(1'b1, '0, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, '0, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, '0, 16'hFFFF, 1'b1, 1'b1);
    check_tok("s6_end", 2, 0, 0, 1);
    step(1'b1, lane(2, 5), 16'hFFFF, 1'b0, 1'b1);
    check_tok("s6_next", 1, 5, 2, 0);
    idle(4);

    // in_last on a match window in RUN: last flag set, no skip carried over.
    step(1'b1, lane(11, 6), 16'hFFFF, 1'b1, 1'b1);
    check_tok("s7_last_match", 1, 6, 11, 1);
    step(1'b1, lane(4, 3), 16'hFFFF, 1'b0, 1'b1);
    check_tok("s7_no_carry", 1, 3, 4, 0);
    idle(2);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      lv = '0;
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 11);
        lv[i*5 +: 5] = (r == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) lv = '0;
      step(1'($urandom_range(0, 9) < 8), lv, 16'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) < 7));
    end

    // Reset in the middle of a skip run drops everything and returns to RUN.
    idle(40);
    step(1'b1, lane(1, 9), 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, '0, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, '0, 16'hFFFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, lane(2, 5), 16'hFFFF, 1'b0, 1'b1);
    check_tok("mid_rst_run", 1, 5, 2, 0);
    idle(6);

    // Every model token since the last reset was taken exactly once.
    check("tokens_taken", 32'(seen_taken + 1), 32'(m_emitted));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_select_ctrl.md
# match_select_ctrl

Per-position match scheduler for the Deflate match stage. Each cycle it accepts one window of 16 candidate match lengths, one per hash-bank lane. It picks the longest candidate, with ties going to the lowest lane, and decides whether to emit a literal or a match token. It then suppresses the windows covered by an emitted match. It sits between the hash-bank compare lanes and the LZ77 token packer, with valid/ready on both sides.

## Interface
- LANES, 16, candidate lanes per window (fixed at 16 by the max tree)
- LEN_W, 5, candidate length width
- IDX_W, 4, lane index width
- MIN_LEN, 3, minimum length emitted as a match
- ap_clk  in  1  clock
- ap_rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  window valid
- in_ready  out  1  window accepted when in_valid && in_ready
- in_len  in  LANES*LEN_W  lane i at [i*LEN_W +: LEN_W]
- in_mask  in  LANES  lane valid; a cleared lane counts as length 0
- in_last  in  1  final window of the block
- out_valid  out  1  token valid
- out_ready  in  1  token consumed when out_valid && out_ready
- out_kind  out  2  0 literal, 1 match, 2 end-only
- out_len  out  LEN_W  match length; 0 for kinds 0 and 2
- out_idx  out  IDX_W  winning lane; 0 for kinds 0 and 2
- out_last  out  1  token closes the block

## Operation
- Max/argmax over masked lengths; strict > comparison, so ties keep the lower index.
- FSM states:
  - RUN:
    - If the window max is >= MIN_LEN: emit a match token (len = max, idx = argmax), load skip_cnt = max-1, go to SKIP.
    - Otherwise: emit a literal token.
  - SKIP:
    - Each accepted window is consumed with no token and skip_cnt decrements.
    - When a window is accepted with skip_cnt == 1, go to RUN.
- in_last handling:
  - In RUN: the emitted token carries out_last=1; skip_cnt is cleared and the FSM stays in RUN (no carry-over into the next block).
  - In SKIP: emit an end-only token (kind 2, len 0, idx 0, out_last=1), clear skip_cnt, go to RUN.
- Width rule: skip_cnt is LEN_W bits; a max of 31 gives skip_cnt 30. No wrap is possible because max >= MIN_LEN >= 2.
- Reset values:
  - out_valid 0, out_kind 0, out_len 0, out_idx 0, out_last 0.
  - State RUN, skip_cnt 0.
  - in_ready forced 0 while ap_rst_n is low.
- Reset mid-block: any pending token is dropped and the FSM returns to RUN. Upstream restarts the block.

## Timing
- One output register. A token is visible on out_valid the cycle after its window is accepted (latency 1).
- in_ready = !out_valid || out_ready, in every state. SKIP windows are accepted under the same rule.
- Full throughput: one window per cycle while out_ready is held high.
- Back-pressure: while out_valid && !out_ready, all out_* fields hold stable and no window is accepted.
- Simultaneous out_ready and in_valid: the old token retires and the new token loads in the same edge.
- The FSM and skip_cnt update only on accepted windows.

## Configuration
- MATCH_SELECT_STATS_EN defined adds:
  - Ports stat_clr (in, 1), stat_lit_cnt (out, 32), stat_match_cnt (out, 32).
  - Counters increment when a literal or match token is accepted downstream; end-only tokens are not counted.
  - Counters saturate at 2^32-1, reset to 0, and clear synchronously on stat_clr. Clear wins over a same-cycle increment.
- MATCH_SELECT_STATS_EN undefined: the stat ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package match_select_pkg holds:
  - LANES, LEN_W, IDX_W, MIN_LEN defaults.
  - The out_kind enum (KIND_LIT, KIND_MATCH, KIND_END).
  - The FSM state typedef (ST_RUN, ST_SKIP).
- Sub-module match_select_max16: combinational 16-lane masked max/argmax tree with lowest-index tie-break, 4 compare levels. The parent holds the FSM, skip counter, output register and handshake.

## Test plan
- Lane 5 = 7, all others 0, out_ready high, 8 windows with the rest all 0:
  - Token (match, 7, 5).
  - The next 6 windows emit nothing.
  - Window 8 emits (literal, 0, 0).
- Lanes 3 and 12 = 9, rest 0 -> (match, 9, 3).
- All lanes ≤ 2, maximum 2 -> (literal, 0, 0); FSM stays RUN.
- in_mask[0]=0 with lane 0 = 31, lane 1 = 4 -> (match, 4, 1).
- Back-pressure:
  - Stimulus: a match token pending, out_ready low for 5 cycles, then high.
  - in_ready is 0 during the stall and out_* fields are unchanged.
  - Releasing out_ready emits the token exactly once, with no lost windows.
- in_last during SKIP:
  - Stimulus: match len 10, then in_last on the 3rd following window.
  - Response: (end-only, 0, 0, last=1) and the FSM is back in RUN.
  - The next block's first window with lane 2 = 5 gives (match, 5, 2).
